// File: rtl/core_pkg.sv
// Shared core definitions for the shift execute path: op encoding, micro-op
// layout and the decode used by both issue logic and the execute stage.
package core_pkg;

  localparam int XLEN    = 32;
  localparam int RD_BITS = 5;

  localparam logic [2:0] FUNCT3_SLL = 3'b001;
  localparam logic [2:0] FUNCT3_SRX = 3'b101;

  typedef enum logic [1:0] {
    SLL  = 2'b00,
    SRL  = 2'b01,
    SRA  = 2'b10,
    NONE = 2'b11
  } shift_op_e;

  typedef struct packed {
    logic [XLEN-1:0]    rs1;
    logic [4:0]         amt;
    logic [RD_BITS-1:0] rd;
    shift_op_e          op;
    logic               illegal;
  } shift_uop_t;

  // Illegal encodings map to NONE so the shifter produces zero for them.
  function automatic shift_uop_t decode_shift(
    input logic [2:0]         funct3,
    input logic               funct7_5,
    input logic               imm_sel,
    input logic [XLEN-1:0]    rs1,
    input logic [4:0]         rs2_amt,
    input logic [4:0]         shamt_imm,
    input logic [RD_BITS-1:0] rd
  );
    shift_uop_t u;
    u.rs1     = rs1;
    u.amt     = imm_sel ? shamt_imm : rs2_amt;
    u.rd      = rd;
    u.op      = NONE;
    u.illegal = 1'b0;
    case (funct3)
      FUNCT3_SLL: begin
        if (funct7_5) u.illegal = 1'b1;
        else          u.op      = SLL;
      end
      FUNCT3_SRX: u.op = funct7_5 ? SRA : SRL;
      default:    u.illegal = 1'b1;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/shift_exec_stage_shifter.sv
// Combinational 32-bit barrel shifter with a 5-bit amount; NONE yields zero.
module shifter
  import core_pkg::*;
(
  input  shift_op_e       op,
  input  logic [4:0]      amt,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] dout
);

  always_comb begin
    dout = '0;
    case (op)
      SLL:     dout = din << amt;
      SRL:     dout = din >> amt;
      SRA:     dout = $unsigned($signed(din) >>> amt);
      default: dout = '0;
    endcase
  end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage shift execute: S1 holds the decoded micro-op feeding the shifter,
// S2 holds the result toward writeback. Full backpressure, flush, retire count.
module shift_exec_stage
  import core_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int RD_W   = RD_BITS,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7_5,
  input  logic              in_imm_sel,
  input  logic [DATA_W-1:0] in_rs1_data,
  input  logic [DATA_W-1:0] in_rs2_data,
  input  logic [4:0]        in_shamt_imm,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  retired_cnt
);

  logic [2:1]       vld_pipe;
  logic             s1_adv, s2_adv, accept, retire;
  shift_uop_t       s1_d, s1_q;
  logic [XLEN-1:0]  sh_out;
  logic [CNT_W-1:0] cnt_q;
  logic             unused_rs2;

  // Only the low five rs2 bits form a shift amount.
  assign unused_rs2 = ^in_rs2_data[DATA_W-1:5];

  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign s1_adv    = !vld_pipe[1] || s2_adv;
  assign in_ready  = s1_adv;
  assign accept    = in_valid && in_ready;
  assign out_valid = vld_pipe[2];
  assign retire    = vld_pipe[2] && out_ready;

  assign s1_d = decode_shift(in_funct3, in_funct7_5, in_imm_sel, in_rs1_data,
                             in_rs2_data[4:0], in_shamt_imm, in_rd);

  shifter u_shifter (
    .op   (s1_q.op),
    .amt  (s1_q.amt),
    .din  (s1_q.rs1),
    .dout (sh_out)
  );

  // Flush wins over any advance; data registers are left as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      if (s1_adv) vld_pipe[1] <= in_valid;
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else if (accept && !flush) begin
      s1_q <= s1_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result  <= '0;
      out_rd      <= '0;
      out_illegal <= 1'b0;
    end else if (vld_pipe[1] && s2_adv && !flush) begin
      out_result  <= sh_out;
      out_rd      <= s1_q.rd;
      out_illegal <= s1_q.illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (retire && cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Directed bench for shift_exec_stage with hand-computed expected values.
module tb_shift_exec_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready;
  logic [2:0]  in_funct3;
  logic        in_funct7_5, in_imm_sel;
  logic [31:0] in_rs1_data, in_rs2_data;
  logic [4:0]  in_shamt_imm, in_rd;
  logic        out_valid, out_ready, out_illegal;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic [15:0] retired_cnt;

  int passed = 0;
  int total  = 0;
  logic [15:0] expcnt = '0;

  shift_exec_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7_5(in_funct7_5), .in_imm_sel(in_imm_sel),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_shamt_imm(in_shamt_imm), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_illegal(out_illegal), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic f75, input logic imm,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [4:0] sh, input logic [4:0] rd);
    in_valid = 1'b1; in_funct3 = f3; in_funct7_5 = f75; in_imm_sel = imm;
    in_rs1_data = rs1; in_rs2_data = rs2; in_shamt_imm = sh; in_rd = rd;
  endtask

  task automatic bump();
    if (expcnt != 16'hFFFF) expcnt = expcnt + 16'd1;
  endtask

  // One isolated op with out_ready high: accept, S1, S2 visible, then retired.
  task automatic single(input string tag, input logic [2:0] f3, input logic f75,
                        input logic imm, input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [4:0] sh, input logic [4:0] rd,
                        input logic [31:0] exp_res, input logic exp_ill);
    issue(f3, f75, imm, rs1, rs2, sh, rd);
    step();
    in_valid = 1'b0;
    step();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_result"}, out_result, exp_res);
    chk({tag, "_rd"}, 32'(out_rd), 32'(rd));
    chk({tag, "_illegal"}, 32'(out_illegal), 32'(exp_ill));
    step();
    bump();
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    chk({tag, "_cnt"}, 32'(retired_cnt), 32'(expcnt));
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    issue(3'b001, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0, 5'd0);
    in_valid = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_illegal", 32'(out_illegal), 32'd0);
    chk("rst_cnt", 32'(retired_cnt), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back SLL imm 4 then SRL by rs2 (amount 1).
    step();
    out_ready = 1'b1;
    issue(3'b001, 1'b0, 1'b1, 32'h0000_00F1, 32'h0, 5'd4, 5'd3);
    #1 chk("b2b_ready0", 32'(in_ready), 32'd1);
    step();
    issue(3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0021, 5'd0, 5'd4);
    chk("b2b_c1_valid", 32'(out_valid), 32'd0);
    chk("b2b_ready1", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("b2b_c2_valid", 32'(out_valid), 32'd1);
    chk("b2b_c2_result", out_result, 32'h0000_0F10);
    chk("b2b_c2_rd", 32'(out_rd), 32'd3);
    step();
    bump();
    chk("b2b_c3_valid", 32'(out_valid), 32'd1);
    chk("b2b_c3_result", out_result, 32'h4000_0000);
    chk("b2b_c3_rd", 32'(out_rd), 32'd4);
    chk("b2b_c3_cnt", 32'(retired_cnt), 32'(expcnt));
    step();
    bump();
    chk("b2b_c4_valid", 32'(out_valid), 32'd0);
    chk("b2b_c4_cnt", 32'(retired_cnt), 32'(expcnt));

    single("sra31", 3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'h0, 5'd31, 5'd5, 32'hFFFF_FFFF, 1'b0);
    single("sra0", 3'b101, 1'b1, 1'b1, 32'h1234_5678, 32'h0, 5'd0, 5'd6, 32'h1234_5678, 1'b0);
    single("sll0", 3'b001, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 5'd7, 5'd7, 32'hDEAD_BEEF, 1'b0);
    single("srl_rs2hi", 3'b101, 1'b0, 1'b0, 32'hF000_0000, 32'hFFFF_FFE4, 5'd0, 5'd8, 32'h0F00_0000, 1'b0);
    single("sra_neg4", 3'b101, 1'b1, 1'b1, 32'h8000_0010, 32'h0, 5'd4, 5'd9, 32'hF800_0001, 1'b0);
    single("ill_f3", 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0, 5'd3, 5'd10, 32'h0, 1'b1);
    single("ill_sllf7", 3'b001, 1'b1, 1'b1, 32'h0000_0001, 32'h0, 5'd2, 5'd11, 32'h0, 1'b1);

    // Backpressure: three ops with out_ready low, then drain in order.
    out_ready = 1'b0;
    issue(3'b001, 1'b0, 1'b1, 32'h1, 32'h0, 5'd1, 5'd12);
    step();
    issue(3'b001, 1'b0, 1'b1, 32'h1, 32'h0, 5'd2, 5'd13);
    #1 chk("bp_ready_b", 32'(in_ready), 32'd1);
    step();
    issue(3'b101, 1'b0, 1'b1, 32'h100, 32'h0, 5'd4, 5'd14);
    #1 chk("bp_ready_full", 32'(in_ready), 32'd0);
    chk("bp_valid_a", 32'(out_valid), 32'd1);
    chk("bp_result_a", out_result, 32'h2);
    step();
    chk("bp_hold_ready", 32'(in_ready), 32'd0);
    chk("bp_hold_result", out_result, 32'h2);
    chk("bp_hold_rd", 32'(out_rd), 32'd12);
    chk("bp_hold_cnt", 32'(retired_cnt), 32'(expcnt));
    out_ready = 1'b1;
    #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    bump();
    chk("bp_drain_b", out_result, 32'h4);
    chk("bp_drain_b_rd", 32'(out_rd), 32'd13);
    step();
    bump();
    chk("bp_drain_c", out_result, 32'h10);
    chk("bp_drain_c_rd", 32'(out_rd), 32'd14);
    step();
    bump();
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_cnt", 32'(retired_cnt), 32'(expcnt));

    // Flush with both stages full and writeback stalled.
    out_ready = 1'b0;
    issue(3'b001, 1'b0, 1'b1, 32'h3, 32'h0, 5'd1, 5'd15);
    step();
    issue(3'b001, 1'b0, 1'b1, 32'h3, 32'h0, 5'd2, 5'd16);
    step();
    in_valid = 1'b0;
    chk("fl_full_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready), 32'd1);
    chk("fl_cnt", 32'(retired_cnt), 32'(expcnt));
    out_ready = 1'b1;
    step();
    chk("fl_s1_gone", 32'(out_valid), 32'd0);

    // An op offered in the flush cycle is dropped.
    flush = 1'b1;
    issue(3'b001, 1'b0, 1'b1, 32'h5, 32'h0, 5'd1, 5'd17);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk("fl_drop_c2", 32'(out_valid), 32'd0);
    step();
    chk("fl_drop_c3", 32'(out_valid), 32'd0);
    chk("fl_drop_cnt", 32'(retired_cnt), 32'(expcnt));

    // Stream ops until the counter reaches all-ones, then one more.
    begin
      int n = 32'hFFFF - int'(expcnt);
      issue(3'b001, 1'b0, 1'b1, 32'h1, 32'h0, 5'd1, 5'd1);
      repeat (n) step();
      in_valid = 1'b0;
      repeat (3) step();
      repeat (n) bump();
    end
    chk("sat_reach", 32'(retired_cnt), 32'h0000_FFFF);
    single("sat_hold", 3'b001, 1'b0, 1'b1, 32'h1, 32'h0, 5'd31, 5'd2, 32'h8000_0000, 1'b0);

    // Asynchronous reset with a result held in S2.
    out_ready = 1'b0;
    issue(3'b001, 1'b0, 1'b1, 32'h7, 32'h0, 5'd4, 5'd21);
    step();
    in_valid = 1'b0;
    step();
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_result", out_result, 32'd0);
    chk("ar_rd", 32'(out_rd), 32'd0);
    chk("ar_illegal", 32'(out_illegal), 32'd0);
    chk("ar_cnt", 32'(retired_cnt), 32'd0);
    chk("ar_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Pipelined execute stage for shift instructions in the core.
- Accepts decoded shift micro-ops from the issue stage over a valid/ready handshake.
- Resolves the operand and shift amount, and drives the combinational shifter.
- Registers the result toward writeback with full backpressure, plus flush and a saturating retire counter.

Parameters:
- DATA_W, `INSTRUCTION_WIDTH (32): operand/result width; fixed at 32 because the shifter is 32-bit with a 5-bit amount.
- RD_W, 5: destination register index width.
- CNT_W, 16: retired-op counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  issue presents a micro-op.
- in_ready  out  1  stage accepts the micro-op this cycle.
- in_funct3  in  3  001=SLL, 101=SRL/SRA; others illegal.
- in_funct7_5  in  1  with funct3=101: 0=SRL, 1=SRA.
- in_imm_sel  in  1  1: amount=in_shamt_imm; 0: amount=in_rs2_data[4:0].
- in_rs1_data  in  DATA_W  value to shift.
- in_rs2_data  in  DATA_W  register shift source.
- in_shamt_imm  in  5  immediate shift amount.
- in_rd  in  RD_W  destination index.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts.
- out_result  out  DATA_W  shifted value.
- out_rd  out  RD_W  destination index.
- out_illegal  out  1  micro-op had an unsupported encoding.
- retired_cnt  out  CNT_W  saturating count of accepted results.

Behaviour:
- Reset: all valid bits 0, out_result 0, out_rd 0, out_illegal 0, retired_cnt 0, in_ready 1.
- Two register stages: S1 (operand/decode) and S2 (result). Latency from input handshake to out_valid is 2 cycles with no stall.
- S1 capture on in_valid && in_ready stores:
  - rs1 data
  - selected 5-bit amount (upper rs2 bits ignored)
  - rd
  - 2-bit op_selector: 00 SLL, 01 SRL, 10 SRA
  - illegal flag
- Illegal encoding: any funct3 other than 001/101, or funct3=001 with funct7_5=1. It sets the illegal flag and op_selector=11, so the shifter yields 0.
- S1 feeds the shifter combinationally. S2 captures the shifter output, rd and illegal flag when S1 is valid and S2 can advance.
- Ready chain:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv
  - in_ready is combinational, with no path from in_valid.
- Simultaneous events:
  - S2 drains and refills in the same cycle, giving full throughput of 1 op/cycle.
  - S1 holds its contents while S2 is stalled.
  - out_* stay stable while out_valid && !out_ready.
- Flush:
  - Clears the S1 and S2 valid bits on the next edge; data registers need not clear.
  - An input offered in the flush cycle is dropped; in_ready may be 1 but the op is discarded.
  - Flush has priority over every capture.
- retired_cnt increments on each out_valid && out_ready, including illegal ops, and saturates at all-ones. Flush does not clear it.
- Reset mid-operation: asynchronous clear of all state, outputs take their reset values immediately.
- Amount 0 passes rs1 unchanged for all three ops. SRA of a negative value fills with ones.

Decomposition:
- Shared package core_pkg holds:
  - shift_op_e enum (SLL=2'b00, SRL=2'b01, SRA=2'b10, NONE=2'b11)
  - FUNCT3_SLL=3'b001, FUNCT3_SRX=3'b101
  - struct shift_uop_t {rs1, amt, rd, op, illegal}
- The existing shifter module is instantiated once as the sole sub-module.
- The decode function lives in the package for reuse by other issue logic.

Test Plan:
- Back-to-back SLL, imm 4, rs1=0x0000_00F1, then SRL, rs2=0x0000_0021 (amt 1), rs1=0x8000_0000, with out_ready=1 → results 0x0000_0F10 then 0x4000_0000 at cycles 2 and 3; in_ready stays 1.
- SRA, amt 31, rs1=0x8000_0000 → 0xFFFF_FFFF. SRA, amt 0, rs1=0x1234_5678 → 0x1234_5678.
- funct3=000 → out_illegal=1, out_result=0, retired_cnt increments.
- Three ops issued with out_ready held 0:
  - S1 and S2 fill, in_ready drops to 0 after two accepts, and out_* stay stable.
  - Releasing out_ready drains all three in order, one per cycle.
- With S1 and S2 full, assert flush for 1 cycle → out_valid=0 next cycle, nothing retires, in_ready=1.
- Preload so the counter reaches 0xFFFF and retire one more op → retired_cnt stays 0xFFFF. Assert rst_n low mid-stream → all outputs zero asynchronously.
